// File: rtl/b2b_event_arbiter_if.sv
// Bundles the cluster FIFO read side and output-board write side of the
// board-to-board event arbiter; the arbiter takes the slave view.
interface b2b_event_arbiter_if #(
  parameter int DATA_WIDTH          = 65,
  parameter int TOTAL_CLUSTERS      = 4,
  parameter int TOTAL_OUTPUT_BOARDS = 14
);
  logic [TOTAL_CLUSTERS-1:0][DATA_WIDTH-1:0]      cluster_data;
  logic [TOTAL_CLUSTERS-1:0]                      cluster_empty;
  logic [TOTAL_CLUSTERS-1:0]                      cluster_req;
  logic [TOTAL_OUTPUT_BOARDS-1:0][DATA_WIDTH-1:0] output_board_event;
  logic [TOTAL_OUTPUT_BOARDS-1:0]                 output_board_wren;
  logic [TOTAL_OUTPUT_BOARDS-1:0]                 output_board_almost_full;
  logic                                           busy;
  logic [15:0]                                    err_count;

  modport slave (
    input  cluster_data, cluster_empty, output_board_almost_full,
    output cluster_req, output_board_event, output_board_wren, busy, err_count
  );

  modport master (
    output cluster_data, cluster_empty, output_board_almost_full,
    input  cluster_req, output_board_event, output_board_wren, busy, err_count
  );
endinterface

// File: rtl/b2b_event_arbiter.sv
// Packet-aware round-robin arbiter: drains whole events from FWFT cluster FIFOs
// and replicates every word to all output boards named in the header mask.
module b2b_event_arbiter #(
  parameter int DATA_WIDTH          = 65,
  parameter int TOTAL_CLUSTERS      = 4,
  parameter int TOTAL_OUTPUT_BOARDS = 14
) (
  input  logic                 b2b_clk,
  input  logic                 b2b_srst,
  b2b_event_arbiter_if.slave   io_if
);
  localparam int CW = (TOTAL_CLUSTERS > 1) ? $clog2(TOTAL_CLUSTERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t                         r_state, w_state_nxt;
  logic [CW-1:0]                  r_rr_ptr, w_rr_nxt;
  logic [CW-1:0]                  r_grant, w_grant_nxt;
  logic [TOTAL_OUTPUT_BOARDS-1:0] r_mask, w_mask_nxt;
  logic [TOTAL_OUTPUT_BOARDS-1:0] r_wren_p1, w_wren_nxt;
  logic [DATA_WIDTH-1:0]          r_event_p1, w_event_nxt;
  logic [15:0]                    r_err_count;
  logic                           w_err_inc;
  logic [TOTAL_CLUSTERS-1:0]      w_req, w_cand, w_stray;
  logic                           w_found, w_stray_found, w_pop;
  logic [CW-1:0]                  w_sel, w_stray_sel;
  logic [DATA_WIDTH-1:0]          w_head;

  function automatic logic is_header(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] && (w[DATA_WIDTH-2 -: 8] == 8'hAB);
  endfunction

  function automatic logic is_footer(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] && (w[DATA_WIDTH-2 -: 8] == 8'hCD);
  endfunction

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= TOTAL_CLUSTERS) s = s - TOTAL_CLUSTERS;
    return CW'(s);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Candidate scan: descending loops leave the lowest offset / index selected
  always_comb begin
    w_found       = 1'b0;
    w_sel         = '0;
    w_stray_found = 1'b0;
    w_stray_sel   = '0;
    for (int c = 0; c < TOTAL_CLUSTERS; c++) begin
      w_cand[c]  = !io_if.cluster_empty[c] &&  is_header(io_if.cluster_data[c]);
      w_stray[c] = !io_if.cluster_empty[c] && !is_header(io_if.cluster_data[c]);
    end
    for (int k = TOTAL_CLUSTERS-1; k >= 0; k--) begin
      if (w_cand[rr_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = rr_idx(r_rr_ptr, k);
      end
    end
    for (int c = TOTAL_CLUSTERS-1; c >= 0; c--) begin
      if (w_stray[c]) begin
        w_stray_found = 1'b1;
        w_stray_sel   = CW'(c);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_grant_nxt = r_grant;
    w_mask_nxt  = r_mask;
    w_wren_nxt  = '0;
    w_event_nxt = r_event_p1;
    w_err_inc   = 1'b0;
    w_req       = '0;
    w_pop       = 1'b0;
    w_head      = io_if.cluster_data[r_grant];
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel;
          w_mask_nxt  = io_if.cluster_data[w_sel][TOTAL_OUTPUT_BOARDS-1:0];
          w_state_nxt = (w_mask_nxt != '0) ? S_FWD : S_DROP;
        end else if (w_stray_found) begin
          w_req[w_stray_sel] = 1'b1;
          w_err_inc          = 1'b1;
        end
      end
      S_FWD: begin
        // Any masked destination near full stalls the whole event, keeping lanes in lockstep
        w_pop = !io_if.cluster_empty[r_grant] &&
                !(|(io_if.output_board_almost_full & r_mask));
        if (w_pop) begin
          w_req[r_grant] = 1'b1;
          w_wren_nxt     = r_mask;
          w_event_nxt    = w_head;
          if (is_footer(w_head)) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = rr_idx(r_grant, 1);
          end
        end
      end
      S_DROP: begin
        w_pop = !io_if.cluster_empty[r_grant];
        if (w_pop) begin
          w_req[r_grant] = 1'b1;
          if (is_footer(w_head)) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = rr_idx(r_grant, 1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (b2b_srst) w_req = '0;
  end

  // Stage p0 -> p1: state update and registered write port
  always_ff @(posedge b2b_clk) begin
    if (b2b_srst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_mask      <= '0;
      r_wren_p1   <= '0;
      r_event_p1  <= '0;
      r_err_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_grant    <= w_grant_nxt;
      r_mask     <= w_mask_nxt;
      r_wren_p1  <= w_wren_nxt;
      r_event_p1 <= w_event_nxt;
      if (w_err_inc) r_err_count <= sat_inc16(r_err_count);
    end
  end

  always_comb begin
    for (int i = 0; i < TOTAL_OUTPUT_BOARDS; i++) io_if.output_board_event[i] = r_event_p1;
  end

  assign io_if.cluster_req       = w_req;
  assign io_if.output_board_wren = r_wren_p1;
  assign io_if.busy              = (r_state != S_IDLE);
  assign io_if.err_count         = r_err_count;
endmodule

// File: tb/tb_b2b_event_arbiter.sv
// Bench for b2b_event_arbiter: queue-modelled FWFT cluster FIFOs, captured
// output-board streams, directed tables and a randomized round-robin model.
module tb_b2b_event_arbiter;
  localparam int DW = 65;
  localparam int NC = 4;
  localparam int NB = 14;

  typedef struct {
    logic [NC-1:0] req;
    logic [NB-1:0] wren;
    logic [DW-1:0] ev;
    logic          busy;
  } vec_t;

  logic clk = 1'b0;
  logic srst;
  b2b_event_arbiter_if #(.DATA_WIDTH(DW), .TOTAL_CLUSTERS(NC), .TOTAL_OUTPUT_BOARDS(NB)) bus ();

  b2b_event_arbiter #(.DATA_WIDTH(DW), .TOTAL_CLUSTERS(NC), .TOTAL_OUTPUT_BOARDS(NB)) dut (
    .b2b_clk (clk),
    .b2b_srst(srst),
    .io_if   (bus)
  );

  initial forever #5 clk = ~clk;

  logic [DW-1:0] fq[NC][$];
  logic [DW-1:0] rx[NB][$];
  logic [DW-1:0] ex[NB][$];
  logic [DW-1:0] evw[NC][3][$];
  logic [NC-1:0] req_s;
  logic [NB-1:0] af_s, af_force;
  bit            af_rand;
  int            vec, bad;
  int            pops[NC];
  int            grant_log[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [NB-1:0] m);
    return {1'b1, 8'hAB, 42'($urandom), m};
  endfunction
  function automatic logic [DW-1:0] ftr();
    return {1'b1, 8'hCD, 56'($urandom)};
  endfunction
  function automatic logic [DW-1:0] dat();
    return {1'b0, $urandom, $urandom};
  endfunction
  function automatic bit is_hdr(input logic [DW-1:0] w);
    return w[64] && (w[63:56] == 8'hAB);
  endfunction

  task automatic refresh();
    for (int c = 0; c < NC; c++) begin
      bus.cluster_empty[c] = (fq[c].size() == 0);
      bus.cluster_data[c]  = (fq[c].size() == 0) ? '0 : fq[c][0];
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < NC; c++) begin fq[c].delete(); pops[c] = 0; end
    for (int b = 0; b < NB; b++) begin rx[b].delete(); ex[b].delete(); end
    grant_log.delete();
    refresh();
  endtask

  // One clock: called and returning at a negedge
  task automatic tick();
    logic [NB-1:0] w;
    logic          diff;
    bus.output_board_almost_full = af_force |
      (af_rand ? NB'($urandom & $urandom & $urandom) : '0);
    #4;
    req_s = bus.cluster_req;
    af_s  = bus.output_board_almost_full;
    if (srst) chk("req_in_reset", req_s, '0);
    chk("req_onehot0", $onehot0(req_s), 1'b1);
    for (int c = 0; c < NC; c++)
      if (req_s[c] && fq[c].size() > 0 && is_hdr(fq[c][0])) grant_log.push_back(c);
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (req_s[c]) begin
        if (fq[c].size() == 0) chk("pop_nonempty", 1'b0, 1'b1);
        else begin void'(fq[c].pop_front()); pops[c]++; end
      end
    end
    refresh();
    @(negedge clk);
    w = bus.output_board_wren;
    if (w != '0) begin
      chk("af_block", w & af_s, '0);
      diff = 1'b0;
      for (int b = 1; b < NB; b++)
        if (bus.output_board_event[b] !== bus.output_board_event[0]) diff = 1'b1;
      chk("lane_eq", diff, 1'b0);
    end
    for (int b = 0; b < NB; b++) if (w[b]) rx[b].push_back(bus.output_board_event[b]);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
      done = !bus.busy;
      for (int c = 0; c < NC; c++) if (fq[c].size() != 0) done = 0;
    end
    if (!done) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic cmp_board(input int b);
    chk($sformatf("board%0d_len", b), rx[b].size(), ex[b].size());
    for (int i = 0; i < ex[b].size() && i < rx[b].size(); i++)
      chk($sformatf("board%0d_word%0d", b, i), rx[b][i], ex[b][i]);
  endtask

  task automatic check_reset_outputs(input string nm);
    logic any_ev;
    any_ev = 1'b0;
    for (int b = 0; b < NB; b++) if (bus.output_board_event[b] != '0) any_ev = 1'b1;
    chk({nm, "_wren"}, bus.output_board_wren, '0);
    chk({nm, "_event"}, any_ev, 1'b0);
    chk({nm, "_busy"}, bus.busy, 1'b0);
    chk({nm, "_err"}, bus.err_count, 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[7];
    logic [DW-1:0] w5[5];
    int            n, first_b, ne[NC], nxt[NC], p, total, first_t, last_t, cnt, strays;
    logic [NB-1:0] m;

    vec = 0; bad = 0;
    srst = 1'b1; af_force = '0; af_rand = 0;
    bus.output_board_almost_full = '0;
    clear_all();
    @(negedge clk);

    // Reset values
    do_reset();
    check_reset_outputs("reset");

    // Single event on cluster 2, mask 0x0005, table of per-cycle expectations
    w5[0] = hdr(14'h0005); w5[1] = dat(); w5[2] = dat(); w5[3] = dat(); w5[4] = ftr();
    tbl[0] = '{4'b0000, 14'h0000, '0,    1'b1};
    tbl[1] = '{4'b0100, 14'h0005, w5[0], 1'b1};
    tbl[2] = '{4'b0100, 14'h0005, w5[1], 1'b1};
    tbl[3] = '{4'b0100, 14'h0005, w5[2], 1'b1};
    tbl[4] = '{4'b0100, 14'h0005, w5[3], 1'b1};
    tbl[5] = '{4'b0100, 14'h0005, w5[4], 1'b0};
    tbl[6] = '{4'b0000, 14'h0000, w5[4], 1'b0};
    for (int i = 0; i < 5; i++) fq[2].push_back(w5[i]);
    refresh();
    for (int j = 0; j < 7; j++) begin
      tick();
      chk($sformatf("single_req_c%0d", j), req_s, tbl[j].req);
      chk($sformatf("single_wren_c%0d", j), bus.output_board_wren, tbl[j].wren);
      chk($sformatf("single_ev_c%0d", j), bus.output_board_event[2], tbl[j].ev);
      chk($sformatf("single_busy_c%0d", j), bus.busy, tbl[j].busy);
    end

    // Pointer now 3: cluster 3 must win over cluster 0
    for (int b = 0; b < NB; b++) rx[b].delete();
    fq[0].push_back(hdr(14'h0100)); fq[0].push_back(dat()); fq[0].push_back(ftr());
    fq[3].push_back(hdr(14'h0200)); fq[3].push_back(dat()); fq[3].push_back(ftr());
    refresh();
    n = 0;
    while (rx[8].size() == 0 && rx[9].size() == 0 && n < 20) begin tick(); n++; end
    first_b = (rx[9].size() != 0 && rx[8].size() == 0) ? 9 : (rx[8].size() != 0 ? 8 : -1);
    chk("rr_after_cluster2", first_b, 9);
    drain(50);

    // Fairness: two events per cluster from pointer 0
    do_reset();
    clear_all();
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < NC; c++) begin
        fq[c].push_back(hdr(NB'(1) << c)); fq[c].push_back(dat());
        fq[c].push_back(dat()); fq[c].push_back(ftr());
      end
    refresh();
    drain(200);
    chk("fair_grants", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk($sformatf("fair_grant%0d", i), grant_log[i], i % NC);

    // Backpressure on a masked board for 4 cycles mid-event
    do_reset();
    clear_all();
    ex[5].push_back(hdr(14'h0020));
    for (int i = 0; i < 6; i++) ex[5].push_back(dat());
    ex[5].push_back(ftr());
    foreach (ex[5][i]) fq[1].push_back(ex[5][i]);
    refresh();
    n = 0;
    while (rx[5].size() < 2 && n < 20) begin tick(); n++; end
    chk("bp_started", rx[5].size(), 2);
    af_force = NB'(1) << 5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp_req%0d", i), req_s, '0);
      chk($sformatf("bp_wren%0d", i), bus.output_board_wren, '0);
    end
    af_force = '0;
    drain(50);
    cmp_board(5);

    // Almost-full on a board outside the mask must not stall
    do_reset();
    clear_all();
    ex[0].push_back(hdr(14'h0001));
    for (int i = 0; i < 3; i++) ex[0].push_back(dat());
    ex[0].push_back(ftr());
    foreach (ex[0][i]) fq[3].push_back(ex[0][i]);
    refresh();
    af_force = NB'(1) << 7;
    first_t = -1; last_t = -1; cnt = 0; n = 0;
    while ((fq[3].size() != 0 || bus.busy) && n < 30) begin
      tick();
      if (req_s[3]) begin
        if (first_t < 0) first_t = n;
        last_t = n;
        cnt++;
      end
      n++;
    end
    af_force = '0;
    chk("unmasked_af_pops", cnt, 5);
    chk("unmasked_af_span", last_t - first_t, 4);
    cmp_board(0);

    // Mask-0 event is dropped; then one stray data word in IDLE
    do_reset();
    clear_all();
    fq[1].push_back(hdr(14'h0000)); fq[1].push_back(dat());
    fq[1].push_back(dat()); fq[1].push_back(ftr());
    refresh();
    drain(30);
    n = 0;
    for (int b = 0; b < NB; b++) n += rx[b].size();
    chk("drop_pops", pops[1], 4);
    chk("drop_no_wren", n, 0);
    chk("drop_err", bus.err_count, 16'd0);
    fq[0].push_back(dat());
    refresh();
    drain(10);
    chk("stray_pops", pops[0], 1);
    chk("stray_err", bus.err_count, 16'd1);

    // Reset in the middle of a forwarded event
    do_reset();
    clear_all();
    fq[0].push_back(hdr(14'h0001));
    for (int i = 0; i < 6; i++) fq[0].push_back(dat());
    fq[0].push_back(ftr());
    ex[1].push_back(hdr(14'h0002)); ex[1].push_back(dat()); ex[1].push_back(ftr());
    foreach (ex[1][i]) fq[0].push_back(ex[1][i]);
    refresh();
    n = 0;
    while (rx[0].size() < 2 && n < 20) begin tick(); n++; end
    strays = fq[0].size() - 3;
    chk("midrst_strays", strays, 6);
    do_reset();
    check_reset_outputs("midrst");
    for (int b = 0; b < NB; b++) rx[b].delete();
    drain(60);
    chk("midrst_err", bus.err_count, 16'(strays));
    chk("midrst_board0_quiet", rx[0].size(), 0);
    cmp_board(1);

    // Randomized events checked against a round-robin event-order model
    do_reset();
    clear_all();
    p = 0;
    af_rand = 1;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < NB; b++) begin rx[b].delete(); ex[b].delete(); end
      total = 0;
      for (int c = 0; c < NC; c++) begin
        ne[c] = $urandom_range(1, 3);
        nxt[c] = 0;
        total += ne[c];
        for (int e = 0; e < 3; e++) evw[c][e].delete();
        for (int e = 0; e < ne[c]; e++) begin
          m = ($urandom_range(0, 4) == 0) ? '0 : NB'($urandom);
          evw[c][e].push_back(hdr(m));
          for (int d = $urandom_range(0, 4); d > 0; d--) evw[c][e].push_back(dat());
          evw[c][e].push_back(ftr());
          foreach (evw[c][e][i]) fq[c].push_back(evw[c][e][i]);
        end
      end
      for (int t = 0; t < total; t++) begin
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (p + k) % NC;
          if (nxt[c] < ne[c]) begin
            m = evw[c][nxt[c]][0][NB-1:0];
            for (int b = 0; b < NB; b++)
              if (m[b]) foreach (evw[c][nxt[c]][i]) ex[b].push_back(evw[c][nxt[c]][i]);
            nxt[c]++;
            p = (c + 1) % NC;
            break;
          end
        end
      end
      refresh();
      drain(3000);
      for (int b = 0; b < NB; b++) cmp_board(b);
      chk($sformatf("rand%0d_err", r), bus.err_count, 16'd0);
    end
    af_rand = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
